// File: rtl/fifo_sync.sv
// Single-clock FIFO of 2**ADDR_BITS words with registered read data.
// Define FIFO_SYNC_LEVEL_EN to expose the fill_level occupancy port.
module fifo_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
`ifdef FIFO_SYNC_LEVEL_EN
  output logic                  fifo_full,
  output logic [ADDR_BITS:0]    fill_level
`else
  output logic                  fifo_full
`endif
);

  localparam int unsigned N_REGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] fifo_mem_reg [N_REGS];
  logic [ADDR_BITS-1:0]  w_ptr_r;
  logic [ADDR_BITS-1:0]  r_ptr_r;
  logic [ADDR_BITS:0]    count_r;
  logic                  w_en_r;
  logic                  r_en_r;

  always_comb begin
    fifo_empty = (count_r == '0);
    fifo_full  = (count_r == FULL_CNT);
    w_en_r     = w_en & ~fifo_full;
    r_en_r     = r_en & ~fifo_empty;
  end

`ifdef FIFO_SYNC_LEVEL_EN
  assign fill_level = count_r;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < N_REGS; i++) begin
        fifo_mem_reg[i] <= '0;
      end
    end else if (w_en_r) begin
      fifo_mem_reg[w_ptr_r] <= data_in;
    end
  end

  // Pointers wrap naturally at 2**ADDR_BITS.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
    end else begin
      if (w_en_r) w_ptr_r <= w_ptr_r + PTR_ONE;
      if (r_en_r) r_ptr_r <= r_ptr_r + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      data_out <= '0;
    end else if (r_en_r) begin
      data_out <= fifo_mem_reg[r_ptr_r];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count_r <= '0;
    end else begin
      unique case ({w_en_r, r_en_r})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: hand table, directed corner sequences and random traffic
// compared against a queue-based model of the FIFO.
module tb_fifo_sync;

  localparam int DW = 8;
  localparam int AB = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          resetn;
  logic [DW-1:0] data_in;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_out;
  logic          fifo_empty;
  logic          fifo_full;
`ifdef FIFO_SYNC_LEVEL_EN
  logic [AB:0]   fill_level;
`endif

  fifo_sync #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .data_in   (data_in),
    .w_en      (w_en),
    .r_en      (r_en),
    .data_out  (data_out),
    .fifo_empty(fifo_empty),
`ifdef FIFO_SYNC_LEVEL_EN
    .fifo_full (fifo_full),
    .fill_level(fill_level)
`else
    .fifo_full (fifo_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of stored words plus the last value read out.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, " empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    check({tag, " full"}, 32'(fifo_full), 32'(model_q.size() == DEPTH));
    check({tag, " data_out"}, 32'(data_out), 32'(model_dout));
`ifdef FIFO_SYNC_LEVEL_EN
    check({tag, " fill_level"}, 32'(fill_level), 32'(model_q.size()));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, settle outputs at posedge+1.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit can_w, can_r;
    @(negedge clk);
    w_en = w;
    r_en = r;
    data_in = d;
    @(posedge clk);
    can_w = w && (model_q.size() < DEPTH);
    can_r = r && (model_q.size() > 0);
    if (can_r) model_dout = model_q.pop_front();
    if (can_w) model_q.push_back(d);
    #1;
  endtask

  // Asynchronous reset pulse of 5 ns; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    model_q.delete();
    model_dout = '0;
    #1;
    check({tag, " rst empty"}, 32'(fifo_empty), 32'd1);
    check({tag, " rst full"}, 32'(fifo_full), 32'd0);
    check({tag, " rst data_out"}, 32'(data_out), 32'd0);
    check({tag, " rst w_ptr"}, 32'(dut.w_ptr_r), 32'd0);
    check({tag, " rst r_ptr"}, 32'(dut.r_ptr_r), 32'd0);
    #4;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          e_empty;
    logic          e_full;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    resetn = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    data_in = '0;
    model_dout = '0;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 8'h77};
    vecs[5] = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 8'h77};
    vecs[6] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h77};  // empty: write only
    vecs[7] = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 8'h11};

    #3;
    do_reset("init");

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d full", i), 32'(fifo_full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_dout));
    end

    // Read on empty for 100 cycles.
    do_reset("rdempty");
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      check_model("rdempty");
    end
    check("rdempty r_ptr", 32'(dut.r_ptr_r), 32'd0);

    // Continuous write, reads starting two cycles later; pointers wrap several times.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, i >= 2, 8'($urandom));
      check_model("stream");
    end
    check("stream count", 32'(dut.count_r), 32'd2);

    // Fill past capacity, then drain.
    do_reset("fill");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'($urandom));
      check_model("fill");
    end
    check("fill w_ptr wrap", 32'(dut.w_ptr_r), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      check_model("drain");
    end
    check("drain empty", 32'(fifo_empty), 32'd1);

    // Full with simultaneous read and write: only the read is taken.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom));
    check("refill full", 32'(fifo_full), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    check("full rw full", 32'(fifo_full), 32'd0);
    check_model("full rw");
    step(1'b1, 1'b0, 8'h5A);
    check("full rw refill", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      check_model("full rw drain");
    end

    // Mid-traffic reset at occupancy 7 with non-zero data_out.
    do_reset("mid pre");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom) | 8'h01);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'($urandom));
    check_model("mid pre");
    check("mid count", 32'(dut.count_r), 32'd7);
    do_reset("mid");
    step(1'b0, 1'b1, 8'h00);
    check_model("mid post");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom), 8'($urandom));
      check_model("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
